// File: rtl/cpu_bcd_store_pkg.sv
// Shared CPU definitions for the FX33 (store BCD of VX at I) sequencer.
package cpu_bcd_store_pkg;

   localparam int unsigned ADDR_W_DEF = 12;

   // Decoder match: (instr & OP_FX33_MASK) == OP_FX33 raises start.
   localparam logic [15:0] OP_FX33      = 16'hF033;
   localparam logic [15:0] OP_FX33_MASK = 16'hF0FF;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CONV = 3'd1;
   localparam logic [2:0] S_WR_H = 3'd2;
   localparam logic [2:0] S_WR_T = 3'd3;
   localparam logic [2:0] S_WR_O = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   typedef enum logic [2:0] {
      IDLE = S_IDLE,
      CONV = S_CONV,
      WR_H = S_WR_H,
      WR_T = S_WR_T,
      WR_O = S_WR_O,
      DONE = S_DONE
   } bcd_st_t;

endpackage

// File: rtl/cpu_bcd_store_if.sv
// Memory write port: valid/ready byte write from the BCD sequencer to the arbiter.
interface cpu_bcd_store_if #(
   parameter int unsigned ADDR_W = cpu_bcd_store_pkg::ADDR_W_DEF
);
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_ready;

   modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
   modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);
endinterface

// File: rtl/cpu_bcd.sv
// Combinational 8-bit binary to three-digit BCD converter.
module cpu_bcd (
   input  logic [7:0] bin_i,
   output logic [3:0] hund_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);
   logic [7:0] rem;

   // Hundreds digit is at most 2, so two compares replace a divider.
   always_comb begin
      if (bin_i >= 8'd200) begin
         hund_o = 4'd2;
         rem    = bin_i - 8'd200;
      end else if (bin_i >= 8'd100) begin
         hund_o = 4'd1;
         rem    = bin_i - 8'd100;
      end else begin
         hund_o = '0;
         rem    = bin_i;
      end
      tens_o = 4'(rem / 8'd10);
      ones_o = 4'(rem % 8'd10);
   end
endmodule

// File: rtl/cpu_bcd_store.sv
// FX33 sequencer: latch VX and I, convert to BCD, write three digits at I..I+2.
module cpu_bcd_store
   import cpu_bcd_store_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        vx,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              busy,
   output logic              done,
   cpu_bcd_store_if.master   mem
);
   bcd_st_t           state_q, state_d;
   logic [7:0]        val_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        h_q, t_q, o_q;
   logic [3:0]        h_d, t_d, o_d;

   cpu_bcd u_bcd (
      .bin_i  (val_q),
      .hund_o (h_d),
      .tens_o (t_d),
      .ones_o (o_d)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    state_d = WR_H;
         WR_H:    if (mem.mem_ready) state_d = WR_T;
         WR_T:    if (mem.mem_ready) state_d = WR_O;
         WR_O:    if (mem.mem_ready) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode from registered state only; address/data forced to 0 when idle.
   always_comb begin
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state_q)
         WR_H: begin
            mem.mem_we    = 1'b1;
            mem.mem_addr  = addr_q;
            mem.mem_wdata = {4'b0, h_q};
         end
         WR_T: begin
            mem.mem_we    = 1'b1;
            mem.mem_addr  = addr_q + ADDR_W'(1);
            mem.mem_wdata = {4'b0, t_q};
         end
         WR_O: begin
            mem.mem_we    = 1'b1;
            mem.mem_addr  = addr_q + ADDR_W'(2);
            mem.mem_wdata = {4'b0, o_q};
         end
         default: ;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         val_q   <= '0;
         addr_q  <= '0;
         h_q     <= '0;
         t_q     <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            val_q  <= vx;
            addr_q <= i_addr;
         end
         if (state_q == CONV) begin
            h_q <= h_d;
            t_q <= t_d;
            o_q <= o_d;
         end
      end
   end
endmodule
